seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Programmable serial-pattern detector with a run controller, generalising the fixed 001/100 Mealy detectors.
- Software loads a pattern (1..MAX_LEN bits), a length, an overlap mode and a match target.
- Start/stop arm and disarm the detector. Qualified serial bits are checked with a Mealy match output.
- Matches are counted, and the block stops and flags done when the target count is reached.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits.
- CNT_W, 8, width of the match counter and of the target.
- LEN_W, $clog2(MAX_LEN+1), width of cfg_len.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  config write strobe.
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  input  CNT_W  number of matches before done; 0 = free-running.
- start  input  1  arm pulse.
- stop  input  1  disarm pulse.
- x_valid  input  1  serial bit qualifier.
- x  input  1  serial data bit.
- y  output  1  Mealy match output (combinational).
- match_cnt  output  CNT_W  matches counted since the last start.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- cfg_err  output  1  one-cycle pulse when a config write is rejected.

Behaviour:
- States: IDLE, RUN, DONE.
  - Reset forces IDLE, match_cnt=0, history=0, fill=0, cfg_err=0.
  - Reset config: pattern=...001, len=3, overlap=1, target=0.
  - Reset mid-RUN aborts the run with no match counted that cycle.
- Outputs: busy=(state==RUN), done=(state==DONE). Both are registered state decodes.
- Config write:
  - Accepted only in IDLE or DONE.
  - In RUN, cfg_we is silently ignored (no cfg_err).
  - If cfg_len==0 or cfg_len>MAX_LEN: config is unchanged and cfg_err pulses the following cycle.
  - Config is never changed in RUN.
- IDLE/DONE + start:
  - Next state is RUN.
  - Same edge clears match_cnt, history and fill.
  - x_valid on the start cycle is ignored.
  - stop is ignored outside RUN.
- Data path (history shift register and fill counter):
  - fill saturates at MAX_LEN.
  - In RUN with x_valid=1: history <= {history, x}, fill <= fill+1.
  - Bits with x_valid=0 are skipped, with no state change.
- Mealy output:
  - y = RUN & x_valid & (fill >= len-1) & ({history[len-2:0], x} == pattern[len-1:0]).
  - For len=1, y compares x alone.
  - y is 0 in IDLE and DONE, and 0 during reset.
- On a match (y=1), at the clock edge:
  - match_cnt increments and saturates at 2^CNT_W-1.
  - If cfg_overlap=0, fill clears to 0, so a new match needs len fresh bits. The history content is a don't-care.
  - If cfg_overlap=1, fill and history are retained normally.
  - If target!=0 and the incremented count == target, next state is DONE. y is still asserted in that cycle.
- RUN + stop:
  - Next state is IDLE and match_cnt is held.
  - A match in the same cycle still asserts y and is counted.
  - stop takes priority over the DONE transition (goes to IDLE).
- DONE:
  - Holds match_cnt; x is ignored.
  - Exits only via start (new run) or reset.
  - Config may be rewritten in DONE.
- Latency:
  - y is in the same cycle as the completing bit.
  - match_cnt and done update one edge later.

Test Plan:
- Default config, start, then feed stream 00010101000100101011 (bit0 first, one bit per cycle, x_valid=1) -> y high on bits 3, 11, 14 only; match_cnt=3; busy stays 1.
- cfg pattern=101, len=3, overlap=1, target=0; same stream -> y on bits 5, 7, 16, 18; match_cnt=4.
- Same with overlap=0 -> y on bits 5, 16 only; match_cnt=2.
- Default pattern with target=2; same stream -> y on bits 3, 11; done=1 the cycle after bit 11; bit 14 gives y=0; match_cnt=2; busy=0.
- cfg_we with len=0 in IDLE -> cfg_err pulses once and pattern 001 is still detected. cfg_we in RUN -> ignored, no cfg_err.
- Stop asserted on the cycle of the bit-11 match (default config) -> y=1, match_cnt=2, state IDLE. Then assert rst during a later RUN -> next cycle busy=0, match_cnt=0, y=0.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial-pattern detector with start/stop run control
// Mealy match on qualified bits, match counting, and target-count completion.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               stop,
  input  logic               x_valid,
  input  logic               x,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t               state_q, state_d;
  logic [MAX_LEN-1:0]   pattern_q, pattern_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 overlap_q, overlap_d;
  logic [CNT_W-1:0]     target_q, target_d;
  logic [MAX_LEN-1:0]   history_q, history_d;
  logic [LEN_W-1:0]     fill_q, fill_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [MAX_LEN-1:0]   mask;
  logic [MAX_LEN-1:0]   shifted;
  logic [CNT_W-1:0]     cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pattern_q <= MAX_LEN'(1);
      len_q     <= LEN_W'(3);
      overlap_q <= 1'b1;
      target_q  <= '0;
      history_q <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      target_q  <= target_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // The compare window is the last len-1 stored bits followed by the live bit.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    shifted = {history_q[MAX_LEN-2:0], x};
    y = (state_q == S_RUN) && !rst && x_valid &&
        (fill_q >= len_q - 1'b1) &&
        (((shifted ^ pattern_q) & mask) == '0);
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    target_d  = target_q;
    history_d = history_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;

    if (cfg_we && state_q != S_RUN) begin
      if (cfg_len == '0 || cfg_len > MAX_L) begin
        err_d = 1'b1;
      end else begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        target_d  = cfg_target;
      end
    end

    case (state_q)
      S_RUN: begin
        if (x_valid) begin
          history_d = shifted;
          fill_d    = (fill_q == MAX_L) ? fill_q : fill_q + 1'b1;
        end
        if (y) begin
          cnt_d = cnt_inc;
          if (!overlap_q) fill_d = '0;
        end
        // stop wins over reaching the target
        if (stop) begin
          state_d = S_IDLE;
        end else if (y && target_q != '0 && cnt_inc == target_q) begin
          state_d = S_DONE;
        end
      end
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          history_d = '0;
          fill_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign match_cnt = cnt_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - scoreboard bench for seq_detect_ctrl
// Expected y per qualified bit is queued by the stimulus and checked by a negedge monitor.
module tb_seq_detect_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = 4;
  localparam string STREAM = "00010101000100101011";

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               x_valid = 1'b0;
  logic               x = 1'b0;
  logic               y;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;
  logic               done;
  logic               cfg_err;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .stop(stop), .x_valid(x_valid), .x(x), .y(y),
    .match_cnt(match_cnt), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_q[$];

  // Reference model: 0 idle, 1 run, 2 done; bits holds the qualified bits seen since the last clear.
  int       m_state = 0;
  int       m_cnt   = 0;
  bit       m_bits[$];
  bit [7:0] m_pat = 8'd1;
  int       m_len = 3;
  bit       m_ovl = 1'b1;
  int       m_tgt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (x_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("y_queue_empty", 1, 0);
      end else begin
        bit e;
        e = exp_q.pop_front();
        check("y", int'(y), int'(e));
      end
    end
  end

  function automatic bit model_y(input bit xb);
    int n;
    n = m_bits.size();
    if (m_state != 1) return 1'b0;
    if (n + 1 < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++) begin
      bit w;
      w = (j == m_len - 1) ? xb : m_bits[n - (m_len - 1) + j];
      if (w != m_pat[m_len - 1 - j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic cycle(input bit r, input bit we, input bit v, input bit xb,
                       input bit st, input bit sp);
    bit ye;
    bit err_e;
    rst = r; cfg_we = we; x_valid = v; x = xb; start = st; stop = sp;
    ye = !r && v && model_y(xb);
    if (v) exp_q.push_back(ye);
    err_e = 1'b0;
    if (r) begin
      m_state = 0; m_cnt = 0; m_bits.delete();
      m_pat = 8'd1; m_len = 3; m_ovl = 1'b1; m_tgt = 0;
    end else begin
      if (we && m_state != 1) begin
        if (cfg_len == 0 || cfg_len > MAX_LEN) err_e = 1'b1;
        else begin
          m_pat = cfg_pattern; m_len = int'(cfg_len);
          m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
        end
      end
      if (m_state == 1) begin
        if (v) begin
          m_bits.push_back(xb);
          if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
          if (ye) begin
            if (m_cnt < 255) m_cnt++;
            if (!m_ovl) m_bits.delete();
          end
        end
        if (sp) m_state = 0;
        else if (ye && m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
      end else if (st) begin
        m_state = 1; m_cnt = 0; m_bits.delete();
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; cfg_we = 1'b0; x_valid = 1'b0; start = 1'b0; stop = 1'b0;
    check("busy", int'(busy), int'(m_state == 1));
    check("done", int'(done), int'(m_state == 2));
    check("match_cnt", int'(match_cnt), m_cnt);
    check("cfg_err", int'(cfg_err), int'(err_e));
  endtask

  task automatic cfg_write(input bit [7:0] pat, input int len, input bit ovl, input int tgt);
    cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl; cfg_target = CNT_W'(tgt);
    cycle(0, 1, 0, 0, 0, 0);
  endtask

  task automatic run_stream(input int stop_idx);
    for (int i = 0; i < STREAM.len(); i++) begin
      cycle(0, 0, 1, STREAM[i] == "1", 0, i == stop_idx);
      if (i == stop_idx) break;
    end
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 0);
    check("reset_y", int'(y), 0);

    cycle(0, 0, 0, 0, 1, 0);
    run_stream(-1);
    check("default_cnt", int'(match_cnt), 3);
    check("default_busy", int'(busy), 1);
    cycle(0, 0, 0, 0, 0, 1);

    cfg_write(8'b101, 3, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    run_stream(-1);
    check("ovl_cnt", int'(match_cnt), 4);
    cycle(0, 0, 0, 0, 0, 1);

    cfg_write(8'b101, 3, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    run_stream(-1);
    check("novl_cnt", int'(match_cnt), 2);
    cycle(0, 0, 0, 0, 0, 1);

    cfg_write(8'b001, 3, 1, 2);
    cycle(0, 0, 0, 0, 1, 0);
    run_stream(-1);
    check("target_cnt", int'(match_cnt), 2);
    check("target_done", int'(done), 1);
    check("target_busy", int'(busy), 0);

    cycle(1, 0, 0, 0, 0, 0);
    cfg_write(8'b111, 0, 1, 0);
    check("bad_len_err", int'(cfg_err), 1);
    cycle(0, 0, 0, 0, 1, 0);
    check("err_pulse_once", int'(cfg_err), 0);
    cfg_write(8'b111, 0, 1, 0);
    cfg_write(8'b11, 2, 0, 1);
    run_stream(-1);
    check("run_cfg_ignored_cnt", int'(match_cnt), 3);
    cycle(0, 0, 0, 0, 0, 1);

    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    run_stream(11);
    check("stop_cnt", int'(match_cnt), 2);
    check("stop_busy", int'(busy), 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 1, 0, 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(match_cnt), 0);

    for (int run = 0; run < 40; run++) begin
      cfg_write(8'($urandom), $urandom_range(0, 10), 1'($urandom), $urandom_range(0, 4));
      cycle(0, 0, 1'($urandom), 1'($urandom), 1, 0);
      for (int c = 0; c < 50; c++) begin
        int sel;
        sel = $urandom_range(0, 99);
        if (sel == 0) cycle(1, 0, 1'($urandom), 1'($urandom), 0, 0);
        else if (sel < 3) cycle(0, 0, 1'($urandom), 1'($urandom), 0, 1);
        else if (sel < 5) cycle(0, 0, 0, 0, 1, 0);
        else if (sel < 7) begin
          cfg_pattern = 8'($urandom); cfg_len = LEN_W'($urandom_range(0, 10));
          cfg_overlap = 1'($urandom); cfg_target = CNT_W'($urandom_range(0, 4));
          cycle(0, 1, 1'($urandom), 1'($urandom), 0, 0);
        end
        else cycle(0, 0, $urandom_range(0, 9) < 7, 1'($urandom), 0, 0);
      end
    end

    @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
